// File: rtl/pattern_blinker_if.sv
// pattern_blinker_if: host-side control, pattern-load and LED output bundle
// for pattern_blinker. The master side (host/register bank) drives the run
// controls and write port; the slave side (the sequencer) drives the outputs.
// There is no valid/ready handshake on this bundle: en, prescale and len are
// level signals sampled on every rising clock edge, and wr_en is a single-cycle
// write strobe that is accepted unconditionally on the edge where it is high.
interface pattern_blinker_if #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 8,
    parameter int PRESCALE_W = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic [LW-1:0]         len;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [CHANNELS-1:0]   wr_data;
    logic [CHANNELS-1:0]   blink;
    logic                  step;
    logic                  wrap;

    modport master (
        output en, prescale, len, wr_en, wr_addr, wr_data,
        input  blink, step, wrap
    );

    modport slave (
        input  en, prescale, len, wr_en, wr_addr, wr_data,
        output blink, step, wrap
    );
endinterface

// File: rtl/pattern_blinker.sv
// pattern_blinker: multi-channel LED pattern sequencer. A prescaler produces a
// tick every prescale+1 enabled cycles; each tick loads the pattern RAM entry
// at the pointer into the blink register and advances the pointer, wrapping
// after the last active entry (len of 0 or above DEPTH selects DEPTH entries).
// Optional build macro PATTERN_BLINKER_INIT_EN gives the pattern RAM power-up
// contents (entry i = i) so the block counts in binary with no host writes.
module pattern_blinker #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input logic              clk,
    input logic              rst,
    pattern_blinker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    // Pattern RAM: asynchronous read, synchronous write, never reset.
    logic [CHANNELS-1:0] mem_q [DEPTH];

`ifdef PATTERN_BLINKER_INIT_EN
    // Power-up contents: entry i holds i, truncated/zero-extended to CHANNELS.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = CHANNELS'(i);
        end
    end
`endif

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [CHANNELS-1:0]   blink_q, blink_d;
    logic                  step_q, step_d;
    logic                  wrap_q, wrap_d;

    logic [LW-1:0] len_eff;
    logic [LW-1:0] last_idx;
    logic          at_last;
    logic          tick;

    // Effective length and end-of-pattern detect; >= so a len shrunk below
    // the pointer still wraps on the next tick instead of running to DEPTH.
    always_comb begin
        len_eff = bus.len;
        if ((bus.len == '0) || (bus.len > LW'(DEPTH))) begin
            len_eff = LW'(DEPTH);
        end
        last_idx = len_eff - LW'(1);
        at_last  = (LW'(ptr_q) >= last_idx);
        // >= lets a prescale lowered mid-count fire at once rather than
        // waiting for the counter to roll over.
        tick     = bus.en && (pcnt_q >= bus.prescale);
    end

    // Next-state for divider, pointer and registered outputs.
    always_comb begin
        pcnt_d  = pcnt_q;
        ptr_d   = ptr_q;
        blink_d = blink_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (tick) begin
            pcnt_d  = '0;
            blink_d = mem_q[ptr_q];
            step_d  = 1'b1;
            wrap_d  = at_last;
            ptr_d   = at_last ? '0 : ptr_q + AW'(1);
        end else if (bus.en) begin
            pcnt_d  = pcnt_q + PRESCALE_W'(1);
        end
    end

    // Sequencer state; reset takes priority over enable and tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt_q  <= '0;
            ptr_q   <= '0;
            blink_q <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            ptr_q   <= ptr_d;
            blink_q <= blink_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    // RAM write port, independent of en and reset; a write to the entry
    // being loaded on the same edge is seen only on the next visit.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.blink = blink_q;
    assign bus.step  = step_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_pattern_blinker.sv
// tb_pattern_blinker: directed bench for pattern_blinker. Stimulus pushes the
// expected (cycle, blink, wrap) of each step into exp_q; a monitor pops and
// compares whenever the DUT pulses step.
module tb_pattern_blinker;
    localparam int CH  = 4;
    localparam int DEP = 8;
    localparam int PW  = 16;
    localparam int EW  = 32 + CH + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned cyc = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    pattern_blinker_if #(.CHANNELS(CH), .DEPTH(DEP), .PRESCALE_W(PW)) bus ();

    pattern_blinker #(.CHANNELS(CH), .DEPTH(DEP), .PRESCALE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle counter (cyc = number of rising edges so far).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic push_exp(input int unsigned c, input logic [CH-1:0] b, input logic w);
        exp_q.push_back({c, b, w});
    endtask

    // Monitor: pops one expectation per observed step pulse.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        while (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missed_step: no step at cycle %0d (expected blink %0h)",
                     e[EW-1 -: 32], e[CH:1]);
        end
        check("wrap_without_step", {31'd0, bus.wrap & ~bus.step}, 32'd0);
        if (bus.step === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_step at cycle %0d: blink %0h wrap %0b, expected no step",
                         cyc, bus.blink, bus.wrap);
            end else begin
                e = exp_q.pop_front();
                check("step_cycle", cyc, e[EW-1 -: 32]);
                check("blink", {28'd0, bus.blink}, {28'd0, e[CH:1]});
                check("wrap", {31'd0, bus.wrap}, {31'd0, e[0]});
            end
        end
    end

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) tick_edge();
    endtask

    task automatic check_reset_outputs();
        check("rst_blink", {28'd0, bus.blink}, 32'd0);
        check("rst_step", {31'd0, bus.step}, 32'd0);
        check("rst_wrap", {31'd0, bus.wrap}, 32'd0);
        check("rst_ptr", {29'd0, dut.ptr_q}, 32'd0);
        check("rst_pcnt", {16'd0, dut.pcnt_q}, 32'd0);
    endtask

    task automatic ram_write(input logic [2:0] addr, input logic [CH-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick_edge();
        bus.wr_en   = 1'b0;
    endtask

    // Enter reset with en high (reset must win), set rate and length.
    task automatic enter_reset(input logic [PW-1:0] p, input logic [3:0] l);
        rst          = 1'b0;
        bus.en       = 1'b1;
        bus.prescale = p;
        bus.len      = l;
    endtask

    task automatic start_run(output int unsigned r);
        rst    = 1'b1;
        bus.en = 1'b1;
        r      = cyc;
    endtask

    task automatic drain();
        tick_edge();
        tick_edge();
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int unsigned r;
        int unsigned r2;
        logic [CH-1:0] pat2 [3];
        logic [CH-1:0] pat6 [8];
        pat2 = '{4'hA, 4'h5, 4'hF};
        pat6 = '{4'hC, 4'h3, 4'hF, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        enter_reset(16'd2, 4'd0);

        // Binary count pattern loaded during reset; P=2, full length.
        for (int i = 0; i < DEP; i++) begin
            ram_write(3'(i), CH'(i));
            check_reset_outputs();
        end
        tick_edge();
        check_reset_outputs();
        start_run(r);
        for (int k = 1; k <= 9; k++) push_exp(r + 3 * k, CH'((k - 1) % 8), (k == 8));
        wait_cyc(r + 27);
        bus.en = 1'b0;
        drain();

        // Short pattern A,5,F with P=0: one step per cycle.
        enter_reset(16'd0, 4'd3);
        for (int i = 0; i < 3; i++) ram_write(3'(i), pat2[i]);
        tick_edge();
        check_reset_outputs();
        start_run(r);
        for (int k = 1; k <= 9; k++) push_exp(r + k, pat2[(k - 1) % 3], ((k - 1) % 3 == 2));
        wait_cyc(r + 9);
        bus.en = 1'b0;
        drain();

        // Freeze for 10 cycles mid-count, then resume with remaining count.
        enter_reset(16'd3, 4'd0);
        tick_edge();
        check_reset_outputs();
        start_run(r);
        push_exp(r + 4, 4'hA, 1'b0);
        push_exp(r + 18, 4'h5, 1'b0);
        push_exp(r + 22, 4'hF, 1'b0);
        push_exp(r + 26, 4'h3, 1'b0);
        wait_cyc(r + 5);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_edge();
            check("freeze_blink", {28'd0, bus.blink}, 32'hA);
            check("freeze_step", {31'd0, bus.step}, 32'd0);
            check("freeze_ptr", {29'd0, dut.ptr_q}, 32'd1);
            check("freeze_pcnt", {16'd0, dut.pcnt_q}, 32'd1);
        end
        bus.en = 1'b1;
        wait_cyc(r + 26);
        bus.en = 1'b0;
        drain();

        // Write collision: entry 1 rewritten on the edge that loads it.
        enter_reset(16'd0, 4'd2);
        tick_edge();
        check_reset_outputs();
        start_run(r);
        push_exp(r + 1, 4'hA, 1'b0);
        push_exp(r + 2, 4'h5, 1'b1);
        push_exp(r + 3, 4'hA, 1'b0);
        push_exp(r + 4, 4'h3, 1'b1);
        tick_edge();
        ram_write(3'd1, 4'h3);
        wait_cyc(r + 4);
        bus.en = 1'b0;
        drain();

        // Rate drop mid-count ticks next cycle; len shrunk below ptr wraps.
        enter_reset(16'd100, 4'd0);
        tick_edge();
        check_reset_outputs();
        start_run(r);
        push_exp(r + 51, 4'hA, 1'b0);
        push_exp(r + 62, 4'h3, 1'b0);
        push_exp(r + 73, 4'hF, 1'b0);
        push_exp(r + 84, 4'h3, 1'b0);
        push_exp(r + 95, 4'h4, 1'b0);
        push_exp(r + 106, 4'h5, 1'b1);
        push_exp(r + 117, 4'hA, 1'b0);
        push_exp(r + 128, 4'h3, 1'b1);
        wait_cyc(r + 50);
        check("pcnt_before_rate_drop", {16'd0, dut.pcnt_q}, 32'd50);
        bus.prescale = 16'd10;
        wait_cyc(r + 96);
        check("ptr_before_len_shrink", {29'd0, dut.ptr_q}, 32'd5);
        bus.len = 4'd2;
        wait_cyc(r + 106);
        check("ptr_after_len_shrink", {29'd0, dut.ptr_q}, 32'd0);
        wait_cyc(r + 128);
        bus.en = 1'b0;
        drain();

        // Reset on a tick edge with a write in the same cycle; len above DEPTH.
        enter_reset(16'd1, 4'd15);
        tick_edge();
        check_reset_outputs();
        start_run(r);
        push_exp(r + 2, 4'hA, 1'b0);
        push_exp(r + 4, 4'h3, 1'b0);
        push_exp(r + 6, 4'hF, 1'b0);
        wait_cyc(r + 7);
        rst = 1'b0;
        ram_write(3'd0, 4'hC);
        check_reset_outputs();
        start_run(r2);
        for (int k = 1; k <= 9; k++) push_exp(r2 + 2 * k, pat6[(k - 1) % 8], (k == 8));
        wait_cyc(r2 + 18);
        bus.en = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends with a summary.
    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL timeout: bench did not complete, expected completion before 200000 ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
